// File: rtl/modexpa7_sync_fifo.sv
// ============================================================================
// modexpa7_sync_fifo: single-clock operand FIFO with registered read, flags,
// occupancy count and flush. Define MODEXPA7_SYNC_FIFO_ERR_EN for sticky
// err_ovf/err_unf. Rev 1.0
// ============================================================================
`default_nettype none

module modexpa7_sync_fifo #(
  parameter int BUS_WIDTH     = 128,
  parameter int DEPTH_BITS    = 2,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [BUS_WIDTH-1:0]  d_in,
  input  logic                  rd_en,
  output logic [BUS_WIDTH-1:0]  d_out,
  output logic                  d_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam int NUM_WORDS = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(NUM_WORDS);
  localparam logic [DEPTH_BITS:0]   AF_LVL   = (DEPTH_BITS+1)'(AFULL_THRESH);
  localparam logic [DEPTH_BITS:0]   AE_LVL   = (DEPTH_BITS+1)'(AEMPTY_THRESH);
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [BUS_WIDTH-1:0]  mem [NUM_WORDS];
  logic [DEPTH_BITS-1:0] ptr_wr;
  logic [DEPTH_BITS-1:0] ptr_rd;
  logic [DEPTH_BITS:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still takes a read
  // while refusing the simultaneous write (and vice versa when empty).
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_nxt = count - CNT_ONE;
  end

  // Storage is never reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc)
      mem[ptr_wr] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_wr       <= '0;
      ptr_rd       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      d_out        <= '0;
      d_valid      <= 1'b0;
    end else if (clr) begin
      ptr_wr       <= '0;
      ptr_rd       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      d_valid      <= 1'b0;
    end else begin
      if (wr_acc)
        ptr_wr <= ptr_wr + PTR_ONE;
      if (rd_acc) begin
        ptr_rd <= ptr_rd + PTR_ONE;
        d_out  <= mem[ptr_rd];
      end
      d_valid      <= rd_acc;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_FULL);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_LVL);
      almost_empty <= (count_nxt <= AE_LVL);
    end
  end

`ifdef MODEXPA7_SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr_en && full)
        err_ovf <= 1'b1;
      if (rd_en && empty)
        err_unf <= 1'b1;
    end
  end
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_modexpa7_sync_fifo.sv
// ============================================================================
// tb_modexpa7_sync_fifo: directed self-checking bench for modexpa7_sync_fifo.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_modexpa7_sync_fifo;

`ifdef MODEXPA7_SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, clr, wr_en, rd_en;
  logic [127:0] d_in;
  logic [127:0] d_out;
  logic         d_valid, full, empty, almost_full, almost_empty, err_ovf, err_unf;
  logic [2:0]   count;

  int total = 0;
  int bad   = 0;

  modexpa7_sync_fifo dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .d_valid(d_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0; d_in = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; wr_en = 1'b1; d_in = 128'hDEAD;
    step();
    step();
    idle();
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", count); end
    total++;
    if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
      bad++; $display("FAIL reset_flags got %b exp 0101", {full, empty, almost_full, almost_empty});
    end
    total++;
    if ({d_valid, err_ovf, err_unf} !== 3'b000 || d_out !== 128'h0) begin
      bad++; $display("FAIL reset_out got dv/eo/eu=%b d_out=%h exp 000/0", {d_valid, err_ovf, err_unf}, d_out);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [3:0] exp_flg [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b1010}; // full,empty,af,ae
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; d_in = 128'hA0 + 128'(i);
      step();
      total++;
      if (count !== exp_cnt[i] || {full, empty, almost_full, almost_empty} !== exp_flg[i]) begin
        bad++;
        $display("FAIL fill_%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                 i, count, {full, empty, almost_full, almost_empty}, exp_cnt[i], exp_flg[i]);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow_drain();
    logic [2:0] exp_cnt [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    wr_en = 1'b1; d_in = 128'hFF;
    step();
    wr_en = 1'b0;
    total++;
    if (count !== 3'd4 || full !== 1'b1 || err_ovf !== ERR) begin
      bad++; $display("FAIL ovf got cnt=%0d full=%b err_ovf=%b exp 4/1/%b", count, full, err_ovf, ERR);
    end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      total++;
      if (d_valid !== 1'b1 || d_out !== 128'hA0 + 128'(i) || count !== exp_cnt[i]) begin
        bad++;
        $display("FAIL drain_%0d got dv=%b d_out=%h cnt=%0d exp 1/%h/%0d",
                 i, d_valid, d_out, count, 128'hA0 + 128'(i), exp_cnt[i]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if (d_valid !== 1'b0 || d_out !== 128'hA3 || count !== 3'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL unf got dv=%b d_out=%h cnt=%0d empty=%b exp 0/a3/0/1", d_valid, d_out, count, empty);
    end
    total++;
    if (err_unf !== ERR || err_ovf !== ERR) begin
      bad++; $display("FAIL unf_err got eo=%b eu=%b exp %b/%b", err_ovf, err_unf, ERR, ERR);
    end
    wr_en = 1'b1; rd_en = 1'b1; d_in = 128'h55;
    step();
    idle();
    total++;
    if (count !== 3'd1 || d_valid !== 1'b0 || empty !== 1'b0 || d_out !== 128'hA3) begin
      bad++; $display("FAIL empty_wr_rd got cnt=%0d dv=%b empty=%b d_out=%h exp 1/0/0/a3", count, d_valid, empty, d_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    wr_en = 1'b1; d_in = 128'h56;
    step();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; d_in = 128'h10 + 128'(i);
      step();
      exp = (i == 0) ? 128'h55 : (i == 1) ? 128'h56 : 128'h10 + 128'(i - 2);
      total++;
      if (count !== 3'd2 || d_valid !== 1'b1 || d_out !== exp) begin
        bad++; $display("FAIL b2b_%0d got cnt=%0d dv=%b d_out=%h exp 2/1/%h", i, count, d_valid, d_out, exp);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    wr_en = 1'b1; d_in = 128'h20;
    step();
    wr_en = 1'b0;
    total++;
    if (count !== 3'd3 || almost_full !== 1'b1) begin
      bad++; $display("FAIL pre_clr got cnt=%0d af=%b exp 3/1", count, almost_full);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (count !== 3'd0 || {full, empty, almost_full, almost_empty} !== 4'b0101 ||
        d_out !== 128'h17 || {d_valid, err_ovf, err_unf} !== 3'b000) begin
      bad++;
      $display("FAIL clr got cnt=%0d flags=%b d_out=%h dv/eo/eu=%b exp 0/0101/17/000",
               count, {full, empty, almost_full, almost_empty}, d_out, {d_valid, err_ovf, err_unf});
    end
    wr_en = 1'b1; d_in = 128'h33;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if (d_out !== 128'h33 || d_valid !== 1'b1 || count !== 3'd0) begin
      bad++; $display("FAIL post_clr got d_out=%h dv=%b cnt=%0d exp 33/1/0", d_out, d_valid, count);
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; d_in = 128'h44;
    step();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; d_in = 128'h45;
    step();
    idle();
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || d_out !== 128'h0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid got cnt=%0d empty=%b d_out=%h dv=%b exp 0/1/0/0", count, empty, d_out, d_valid);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if (d_valid !== 1'b0 || count !== 3'd0 || err_unf !== ERR) begin
      bad++; $display("FAIL rst_mid_rd got dv=%b cnt=%0d eu=%b exp 0/0/%b", d_valid, count, err_unf, ERR);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
